// File: rtl/backup_mem_pkg.sv
// Shared definitions for the backup-memory request/response master and its responder.
package backup_mem_pkg;

  typedef enum logic [2:0] {
    BM_IDLE  = 3'd0,
    BM_REQ   = 3'd1,
    BM_WDATA = 3'd2,
    BM_RDATA = 3'd3,
    BM_DONE  = 3'd4
  } bm_state_e;

  localparam int MEM_DATA_CYCLES = 4;
  localparam int MEM_TAG_BITS    = 16;

endpackage

// File: rtl/backup_mem_master.sv
// Initiator for the backup-memory interface: one whole-line read or write in flight,
// sent/received beat by beat and reassembled into a line.
module backup_mem_master
  import backup_mem_pkg::*;
#(
  parameter int ADDR_BITS   = 26,
  parameter int DATA_BITS   = 128,
  parameter int DATA_CYCLES = MEM_DATA_CYCLES,
  parameter int TAG_BITS    = MEM_TAG_BITS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_rw,
  input  logic [ADDR_BITS-1:0]             cmd_addr,
  input  logic [DATA_CYCLES*DATA_BITS-1:0] cmd_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_rw,
  output logic [DATA_CYCLES*DATA_BITS-1:0] rsp_rdata,
  output logic                             rsp_err,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_rw,
  output logic [ADDR_BITS-1:0]             mem_req_addr,
  output logic [TAG_BITS-1:0]              mem_req_tag,
  output logic                             mem_req_data_valid,
  input  logic                             mem_req_data_ready,
  output logic [DATA_BITS-1:0]             mem_req_data_bits,
  input  logic                             mem_resp_valid,
  input  logic [DATA_BITS-1:0]             mem_resp_data,
  input  logic [TAG_BITS-1:0]              mem_resp_tag
);

  localparam int CNT_BITS  = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
  localparam int LINE_BITS = DATA_CYCLES * DATA_BITS;
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(DATA_CYCLES - 1);

  bm_state_e             state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [TAG_BITS-1:0]   tag_ctr_q, tag_ctr_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic                  rw_q, rw_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [LINE_BITS-1:0]  wdata_q, wdata_d;
  logic [LINE_BITS-1:0]  rdata_q, rdata_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tag_ctr_d = tag_ctr_q;
    tag_d     = tag_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    unique case (state_q)
      BM_IDLE: begin
        if (cmd_valid) begin
          rw_d      = cmd_rw;
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          tag_d     = tag_ctr_q;
          tag_ctr_d = tag_ctr_q + 1'b1;
          state_d   = BM_REQ;
        end
      end
      BM_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = rw_q ? BM_WDATA : BM_RDATA;
        end
      end
      BM_WDATA: begin
        if (mem_req_data_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = BM_DONE;
        end
      end
      BM_RDATA: begin
        // Beats carrying someone else's tag are dropped but remembered as an error.
        if (mem_resp_valid) begin
          if (mem_resp_tag == tag_q) begin
            rdata_d[cnt_q*DATA_BITS +: DATA_BITS] = mem_resp_data;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) state_d = BM_DONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BM_DONE: begin
        if (rsp_ready) state_d = BM_IDLE;
      end
      default: state_d = BM_IDLE;
    endcase

    // There is no resp back-pressure, so an unexpected beat can only be flagged.
    if (mem_resp_valid && (state_q != BM_RDATA)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BM_IDLE;
      cnt_q     <= '0;
      tag_ctr_q <= '0;
      tag_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tag_ctr_q <= tag_ctr_d;
      tag_q     <= tag_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign cmd_ready          = (state_q == BM_IDLE);
  assign mem_req_valid      = (state_q == BM_REQ);
  assign mem_req_rw         = rw_q;
  assign mem_req_addr       = addr_q;
  assign mem_req_tag        = tag_q;
  assign mem_req_data_valid = (state_q == BM_WDATA);
  assign mem_req_data_bits  = wdata_q[cnt_q*DATA_BITS +: DATA_BITS];
  assign rsp_valid          = (state_q == BM_DONE);
  assign rsp_rw             = rw_q;
  assign rsp_rdata          = rdata_q;
  assign rsp_err            = err_q;

endmodule
